// File: rtl/quadratic_inverse_map.sv
// quadratic_inverse_map: recovers x[n] = +/-sqrt((1 - x[n+1]) / r) in Q1.15 using one multiply and a bit-serial root.
// Define QMAP_INV_ROUND_EN to round the root to nearest instead of truncating it.
module quadratic_inverse_map (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_next,
  input  logic [15:0] r_inv,
  input  logic        branch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x_prev,
  output logic        sat
);
  typedef enum logic [1:0] {IDLE, MUL, SQRT, DONE} state_t;
  state_t      r_state, w_state_nx;
  logic [15:0] r_x, r_rinv, r_x_prev;
  logic        r_branch, r_sat, r_sat_o, r_out_valid;
  logic [29:0] r_rad;
  logic [14:0] r_root;
  logic [15:0] r_rem;
  logic [3:0]  r_cnt;
  logic [16:0] w_d;
  logic [32:0] w_p;
  logic [17:0] w_rem_sh, w_trial;
  logic [15:0] w_rem_nx, w_m, w_mag;
  logic [14:0] w_root_nx;
  logic        w_ge, w_accept, w_last;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_out_valid;
  assign x_prev    = r_x_prev;
  assign sat       = r_sat_o;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = r_state == SQRT && r_cnt == 4'd0;
  // d = 1.0 - x[n+1] spans 1..65536, so it needs the 17th bit
  assign w_d       = 17'h08000 - {r_x[15], r_x};
  assign w_p       = {16'd0, w_d} * {17'd0, r_rinv};
  // Restoring step: bring down two radicand bits, try subtracting 4*root+1
  assign w_rem_sh  = {r_rem, r_rad[29:28]};
  assign w_trial   = {1'b0, r_root, 2'b01};
  assign w_ge      = w_rem_sh >= w_trial;
  assign w_rem_nx  = 16'(w_ge ? w_rem_sh - w_trial : w_rem_sh);
  assign w_root_nx = {r_root[13:0], w_ge};
`ifdef QMAP_INV_ROUND_EN
  assign w_m = ({2'b0, w_rem_nx} > {3'b0, w_root_nx}) && w_root_nx != 15'h7FFF ?
               {1'b0, w_root_nx} + 16'd1 : {1'b0, w_root_nx};
`else
  assign w_m = {1'b0, w_root_nx};
`endif
  assign w_mag = r_sat ? 16'h7FFF : w_m;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = w_accept ? MUL : IDLE;
      MUL:     w_state_nx = SQRT;
      SQRT:    w_state_nx = r_cnt == 4'd0 ? DONE : SQRT;
      default: w_state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_rinv <= '0;
      r_branch <= 1'b0;
      r_sat <= 1'b0;
      r_rad <= '0;
      r_root <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_out_valid <= 1'b0;
      r_x_prev <= '0;
      r_sat_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x <= x_next;
        r_rinv <= r_inv;
        r_branch <= branch;
      end
      if (r_state == MUL) begin
        r_sat <= |w_p[32:29];
        r_rad <= {w_p[28:0], 1'b0};
        r_root <= '0;
        r_rem <= '0;
        r_cnt <= 4'd14;
      end
      if (r_state == SQRT) begin
        r_rad <= {r_rad[27:0], 2'b00};
        r_root <= w_root_nx;
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt - 4'd1;
      end
      // Result registers load on the last root step so out_valid rises with DONE
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_x_prev <= r_branch ? 16'd0 - w_mag : w_mag;
        r_sat_o <= r_sat;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_quadratic_inverse_map.sv
// tb_quadratic_inverse_map: directed scoreboard bench for quadratic_inverse_map.
module tb_quadratic_inverse_map;
  logic clk = 0, reset = 0, in_valid = 0, branch = 0, out_ready = 0;
  logic in_ready, out_valid, sat;
  logic [15:0] x_next = 0, r_inv = 0, x_prev;
  typedef struct packed {logic [15:0] x; logic s;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, cyc = 0, acc = 0;
`ifdef QMAP_INV_ROUND_EN
  localparam logic [15:0] RND = 16'h013A;
`else
  localparam logic [15:0] RND = 16'h0139;
`endif
  localparam logic [15:0] NRND = 16'h0000 - RND;

  quadratic_inverse_map dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_next(x_next), .r_inv(r_inv), .branch(branch), .out_valid(out_valid),
    .out_ready(out_ready), .x_prev(x_prev), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] ri, input logic b,
                       input logic [15:0] ex, input logic es);
    int n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("issue_ready", in_ready, 1);
    x_next = x; r_inv = ri; branch = b; in_valid = 1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
    e.x = ex; e.s = es;
    q.push_back(e);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_lat"}, cyc - acc, 16);
    chk({tag, "_busy"}, in_ready, 0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_x"}, x_prev, e.x);
      chk({tag, "_sat"}, sat, e.s);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_ovclr"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_x", x_prev, 0);
    chk("rst_sat", sat, 0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    issue(16'h0000, 16'h4000, 0, 16'h7FFF, 1); wait_valid("sat"); handshake("sat");
    issue(16'h4000, 16'h4000, 0, 16'h5A82, 0); out_ready = 1;
    wait_valid("irr"); handshake("irr");
    issue(16'h6000, 16'h4000, 1, 16'hC000, 0); wait_valid("neg"); handshake("neg");
    issue(16'h7FFD, 16'h4000, 0, RND, 0); wait_valid("rnd"); handshake("rnd");
    issue(16'h1234, 16'h0000, 1, 16'h0000, 0); wait_valid("nzero"); handshake("nzero");
    issue(16'h8000, 16'h4000, 1, 16'h8001, 1); wait_valid("satneg"); handshake("satneg");
    issue(16'h4000, 16'h4000, 1, 16'hA57E, 0); wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      x_next = 16'h0000; r_inv = 16'h4000; branch = 0; in_valid = 1;
      @(posedge clk); #1;
      chk("bp_hold_x", x_prev, 16'hA57E);
      chk("bp_hold_sat", sat, 0);
      chk("bp_hold_ov", out_valid, 1);
      chk("bp_hold_rdy", in_ready, 0);
    end
    in_valid = 0;
    handshake("bp");
    issue(16'h6000, 16'h4000, 0, 16'h4000, 0); wait_valid("bp_next"); handshake("bp_next");
    issue(16'h6000, 16'h4000, 0, 16'h4000, 0);
    repeat (8) @(posedge clk);
    #3; reset = 0; #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_x", x_prev, 0);
    void'(q.pop_back());
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    issue(16'h7FFD, 16'h4000, 1, NRND, 0); wait_valid("post_rst"); handshake("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/quadratic_inverse_map.md
# quadratic_inverse_map

- Backward-iteration block for the chaotic quadratic map x[n+1] = 1 − r·x[n]², operating in Q1.15.
- Takes a forward sample x[n+1], the precomputed reciprocal 1/r and a branch (sign) bit, and recovers x[n] = ±sqrt((1 − x[n+1])/r).
- Uses one pipelined multiply followed by a bit-serial restoring square root under a valid/ready handshake.
- Sits at the receive/decode end of the chaotic keystream path, undoing forward map steps.

## Interface

Parameters: none. Widths are fixed by the Q1.15 format.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands; high only in IDLE
- x_next  in  16  signed Q1.15 forward sample x[n+1]
- r_inv  in  16  unsigned Q2.14, equals 1/r
- branch  in  1  0 selects the +root, 1 selects the −root
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- x_prev  out  16  signed Q1.15 recovered x[n]
- sat  out  1  radicand was ≥ 1.0 and the magnitude was clamped

## Operation

- FSM states: IDLE → MUL → SQRT → DONE → IDLE.
- **IDLE:** in_ready = 1. When in_valid && in_ready, capture x_next, r_inv and branch, then go to MUL. Inputs are ignored in every other state.
- **MUL:**
  - d = 32768 − x_next, 17-bit unsigned, range 1..65536.
  - p = d · r_inv, 33-bit unsigned, Q4.29.
  - If p ≥ 2^29, set the sat flag. Otherwise the radicand is R = p << 1, 30 bits, Q0.30.
  - Initialise the root and remainder registers, load iteration count 14, go to SQRT.
- **SQRT:**
  - Restoring integer square root, one result bit per cycle, MSB first, 15 iterations.
  - Result m = floor(sqrt(R)), 0..32767.
  - The final remainder R − m² is retained.
  - When the count reaches 0, go to DONE.
  - Iterations run even when sat is set; the result is then overridden.
- **DONE:**
  - x_prev = branch ? −mag : mag, where mag = sat ? 0x7FFF : m.
  - out_valid = 1. Hold until out_ready, then go to IDLE.
- All outputs are registered except in_ready, which decodes the state.
- No overlap: a new operand is accepted only after the previous result handshakes.

## Timing

- Accept edge E0. MUL completes at E1. SQRT iterations complete at E2..E16. out_valid rises after E16, so latency is 16 cycles from accept to out_valid.
- Result handshake at edge Ek returns to IDLE; in_ready is high in the following cycle. Minimum issue interval is 18 cycles.
- out_ready low: out_valid, x_prev and sat hold stable indefinitely.
- out_ready high before out_valid: no effect.
- Reset values:
  - state = IDLE, so in_ready = 1 during and after reset.
  - out_valid = 0, x_prev = 0x0000, sat = 0.
  - Internal registers are cleared.
- Reset asserted mid-MUL, mid-SQRT or in DONE: the operation is abandoned immediately (asynchronous). No out_valid is produced for it.
- Negative zero: branch = 1 with mag = 0 gives x_prev = 0x0000.

## Configuration

- Macro: `QMAP_INV_ROUND_EN`.
- Defined: in DONE, if the remainder > m, then mag = m + 1, clamped to 0x7FFF. This rounds to the nearest root. Latency is unchanged.
- Undefined: mag = m (truncating root). The remainder comparison logic is not synthesised.
- The sat behaviour is identical in both builds.

## Test plan

- Saturation: x_next = 0x0000, r_inv = 0x4000, branch = 0 → p = 2^29 → x_prev = 0x7FFF, sat = 1. out_valid rises exactly 16 cycles after the accept edge.
- Irrational root: x_next = 0x4000, r_inv = 0x4000, branch = 0 → R = 2^29 → x_prev = 0x5A82, sat = 0, in both builds (remainder 22012 ≤ 23170).
- Exact negative root: x_next = 0x6000, r_inv = 0x4000, branch = 1 → R = 2^28 → x_prev = 0xC000, sat = 0.
- Rounding: x_next = 0x7FFD, r_inv = 0x4000, branch = 0 → R = 98304. Without `QMAP_INV_ROUND_EN`, x_prev = 0x0139 (313). With it, x_prev = 0x013A (314).
- Backpressure: hold out_ready low for 5 cycles after out_valid → x_prev and sat stable, in_ready = 0, and a new in_valid is ignored. Raise out_ready → in_ready = 1 on the next cycle, and the next operand is accepted.
- Reset mid-operation: pull reset low 8 cycles after an accept → out_valid = 0 and in_ready = 1 immediately. After release, a fresh operand completes normally with latency 16.
